mult_div_unit: RTL and testbench

- Iterative signed multiply/divide engine that owns the HI and LO registers of the multicycle CPU.
- The main control unit issues MULT, DIV, MTHI and MTLO through a start/busy/done handshake, and stalls on busy.
- It reads HI and LO through hi_out and lo_out, selected by the MEMtoReg path.
- Division by zero raises a one-cycle flag that the control unit routes to its exception sequence.

---
 rtl/md_pkg.sv | 25 ++
 rtl/md_step.sv | 46 ++++
 rtl/mult_div_unit.sv | 158 +++++++++++++++
 tb/tb_mult_div_unit.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared encodings for the multiply/divide unit and the control unit that drives it.
package md_pkg;

    typedef enum logic [1:0] {
        OP_MULT = 2'b00,
        OP_DIV  = 2'b01,
        OP_MTHI = 2'b10,
        OP_MTLO = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_FINISH = 2'b10
    } state_e;

    // R-type funct codes the control unit decodes into HI/LO operations
    localparam logic [5:0] FUNCT_MFHI = 6'h10;
    localparam logic [5:0] FUNCT_MTHI = 6'h11;
    localparam logic [5:0] FUNCT_MFLO = 6'h12;
    localparam logic [5:0] FUNCT_MTLO = 6'h13;
    localparam logic [5:0] FUNCT_MULT = 6'h18;
    localparam logic [5:0] FUNCT_DIV  = 6'h1A;

endpackage

// File: rtl/md_step.sv
// One iteration of the iterative engine over a 2*WIDTH+1 working register.
// MULT layout: {A, Q, q_-1}; DIV layout: {remainder, quotient, spare}.
module md_step
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               is_div,
    input  logic [WIDTH-1:0]   operand,
    input  logic [2*WIDTH:0]   work_in,
    output logic [2*WIDTH:0]   work_out
);

    logic [WIDTH-1:0] upper;
    logic [WIDTH-1:0] lower;
    logic [WIDTH:0]   booth_sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    // Booth add/sub with arithmetic shift, or restoring shift/subtract
    always_comb begin
        upper     = work_in[2*WIDTH:WIDTH+1];
        lower     = work_in[WIDTH:1];
        booth_sum = {upper[WIDTH-1], upper};
        shifted   = {upper, lower[WIDTH-1]};
        trial     = shifted - {1'b0, operand};
        work_out  = work_in;
        if (is_div) begin
            if (!trial[WIDTH]) begin
                work_out = {trial[WIDTH-1:0], lower[WIDTH-2:0], 1'b1, 1'b0};
            end else begin
                work_out = {shifted[WIDTH-1:0], lower[WIDTH-2:0], 1'b0, 1'b0};
            end
        end else begin
            // Sum is kept one bit wider so a most-negative multiplicand cannot
            // overflow; the shift then drops that extra bit back out.
            case (work_in[1:0])
                2'b01:   booth_sum = booth_sum + {operand[WIDTH-1], operand};
                2'b10:   booth_sum = booth_sum - {operand[WIDTH-1], operand};
                default: ;
            endcase
            work_out = {booth_sum, lower};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed multiply/divide sequencer owning the HI and LO registers.
module mult_div_unit
    import md_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    state_e           state;
    state_e           state_nxt;
    op_e              op_in;
    op_e              op_q;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] opnd_q;
    logic [2*WIDTH:0] work_q;
    logic [2*WIDTH:0] step_out;
    logic             neg_quot_q;
    logic             neg_rem_q;
    logic             done_nxt;
    logic             dz_nxt;
    logic             load;
    logic             wr_hi;
    logic             wr_lo;
    logic             finish;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    assign op_in = op_e'(op);
    assign busy  = (state != ST_IDLE);
    assign rem   = work_q[2*WIDTH:WIDTH+1];
    assign quot  = work_q[WIDTH:1];

    md_step #(.WIDTH(WIDTH)) u_step (
        .is_div   (op_q == OP_DIV),
        .operand  (opnd_q),
        .work_in  (work_q),
        .work_out (step_out)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state and per-cycle control decode
    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        dz_nxt    = 1'b0;
        load      = 1'b0;
        wr_hi     = 1'b0;
        wr_lo     = 1'b0;
        finish    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    case (op_in)
                        OP_MTHI: begin
                            wr_hi    = 1'b1;
                            done_nxt = 1'b1;
                        end
                        OP_MTLO: begin
                            wr_lo    = 1'b1;
                            done_nxt = 1'b1;
                        end
                        OP_DIV: begin
                            if (b_in == '0) begin
                                dz_nxt   = 1'b1;
                                done_nxt = 1'b1;
                            end else begin
                                load      = 1'b1;
                                state_nxt = ST_RUN;
                            end
                        end
                        default: begin
                            load      = 1'b1;
                            state_nxt = ST_RUN;
                        end
                    endcase
                end
            end
            ST_RUN: begin
                if (cnt == CNT_W'(WIDTH - 1)) state_nxt = ST_FINISH;
            end
            ST_FINISH: begin
                finish    = 1'b1;
                done_nxt  = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: operand latch, iteration, result write-back and pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            hi_out     <= '0;
            lo_out     <= '0;
            done       <= 1'b0;
            div_zero   <= 1'b0;
            op_q       <= OP_MULT;
            opnd_q     <= '0;
            work_q     <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
        end else begin
            done     <= done_nxt;
            div_zero <= dz_nxt;
            if (wr_hi) hi_out <= a_in;
            if (wr_lo) lo_out <= a_in;
            if (load) begin
                op_q       <= op_in;
                cnt        <= '0;
                neg_quot_q <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
                neg_rem_q  <= a_in[WIDTH-1];
                if (op_in == OP_DIV) begin
                    opnd_q <= mag(b_in);
                    work_q <= {{WIDTH{1'b0}}, mag(a_in), 1'b0};
                end else begin
                    opnd_q <= a_in;
                    work_q <= {{WIDTH{1'b0}}, b_in, 1'b0};
                end
            end
            if (state == ST_RUN) begin
                work_q <= step_out;
                cnt    <= cnt + 1'b1;
            end
            if (finish) begin
                if (op_q == OP_DIV) begin
                    lo_out <= neg_quot_q ? -quot : quot;
                    hi_out <= neg_rem_q  ? -rem  : rem;
                end else begin
                    hi_out <= rem;
                    lo_out <= quot;
                end
            end
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: latency/arithmetic model plus directed literals.
module tb_mult_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [W-1:0] hi_out;
    logic [W-1:0] lo_out;

    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;

    // Behavioural model state
    logic [W-1:0] m_hi, m_lo, p_hi, p_lo;
    logic         m_done, m_dz;
    int           m_left = 0;

    mult_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .a_in(a_in), .b_in(b_in), .busy(busy), .done(done),
        .div_zero(div_zero), .hi_out(hi_out), .lo_out(lo_out)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached, got running, want finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Result-level reference: fixed latency of W+1 edges, arithmetic from signed math
    always @(posedge clk) begin
        longint sa, sb, p, q, r;
        m_done = 1'b0;
        m_dz   = 1'b0;
        if (reset) begin
            m_hi = '0; m_lo = '0; m_left = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_hi = p_hi; m_lo = p_lo; m_done = 1'b1;
            end
        end else if (start) begin
            sa = $signed(a_in);
            sb = $signed(b_in);
            case (op)
                2'b10: begin m_hi = a_in; m_done = 1'b1; end
                2'b11: begin m_lo = a_in; m_done = 1'b1; end
                2'b01: begin
                    if (b_in == 0) begin
                        m_dz = 1'b1; m_done = 1'b1;
                    end else begin
                        q = sa / sb; r = sa % sb;
                        p_lo = q[31:0]; p_hi = r[31:0]; m_left = W + 1;
                    end
                end
                default: begin
                    p = sa * sb;
                    p_hi = p[63:32]; p_lo = p[31:0]; m_left = W + 1;
                end
            endcase
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (check_en) begin
            chk("busy", W'(busy), W'(m_left > 0));
            chk("done", W'(done), W'(m_done));
            chk("div_zero", W'(div_zero), W'(m_dz));
            chk("hi_out", hi_out, m_hi);
            chk("lo_out", lo_out, m_lo);
        end
    end

    // Issue one request at the current negedge; return at the first negedge with busy low
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        int guard;
        start = 1'b1; op = o; a_in = a; b_in = b;
        @(negedge clk);
        start = 1'b0; a_in = $urandom; b_in = $urandom;
        guard = 0;
        while (busy && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        if (busy) chk("busy_timeout", W'(busy), '0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 2'b00; a_in = '0; b_in = '0;
        @(negedge clk);
        check_en = 1'b1;
        @(negedge clk);
        chk("reset_hi", hi_out, '0);
        chk("reset_lo", lo_out, '0);
        chk("reset_busy", W'(busy), '0);
        reset = 1'b0;

        run_op(2'b00, 32'd7, 32'hFFFF_FFFD);
        chk("mul7_hi", hi_out, 32'hFFFF_FFFF);
        chk("mul7_lo", lo_out, 32'hFFFF_FFEB);
        chk("mul7_done", W'(done), 32'd1);

        run_op(2'b00, 32'h8000_0000, 32'h8000_0000);
        chk("mulmin_hi", hi_out, 32'h4000_0000);
        chk("mulmin_lo", lo_out, 32'h0000_0000);

        run_op(2'b01, 32'hFFFF_FFF9, 32'd2);
        chk("divneg_lo", lo_out, 32'hFFFF_FFFD);
        chk("divneg_hi", hi_out, 32'hFFFF_FFFF);

        run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("divovf_lo", lo_out, 32'h8000_0000);
        chk("divovf_hi", hi_out, 32'h0000_0000);
        chk("divovf_dz", W'(div_zero), '0);

        run_op(2'b10, 32'h0000_1234, 32'd0);
        run_op(2'b01, 32'd5, 32'd0);
        chk("dz_flag", W'(div_zero), 32'd1);
        chk("dz_done", W'(done), 32'd1);
        chk("dz_busy", W'(busy), '0);
        chk("dz_hi", hi_out, 32'h0000_1234);

        // Second start during RUN must be ignored
        start = 1'b1; op = 2'b00; a_in = 32'd6; b_in = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        run_op(2'b00, 32'd3, 32'd3);
        while (busy) @(negedge clk);
        chk("ignore_lo", lo_out, 32'd42);
        chk("ignore_hi", hi_out, 32'd0);

        // Reset in the middle of a multiply aborts it
        start = 1'b1; op = 2'b00; a_in = 32'd1000; b_in = 32'd1000;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", W'(busy), '0);
        chk("abort_hi", hi_out, '0);
        chk("abort_lo", lo_out, '0);
        chk("abort_done", W'(done), '0);

        // Randomized back-to-back traffic, each start issued in the done cycle
        for (int i = 0; i < 40; i++) begin
            logic [1:0]   ro;
            logic [W-1:0] ra, rb;
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: rb = 32'hFFFF_FFFF;
                2: ra = 32'h8000_0000;
                3: rb = 32'($urandom_range(1, 9));
                default: ;
            endcase
            run_op(ro, ra, rb);
        end
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
